core_clk_req_ctrl: RTL and testbench
====================================

CORE_CLK_REQ_CTRL -- requirements
Module: core_clk_req_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: idle hysteresis cycles before gating; legal 1..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: clock-settle cycles after ungating before wake is signalled; legal 1..255.
REQ-003 SHALL have port g_clk, input, 1: free-running clock, the same clock that drives the core clock gate's clk_in.
REQ-004 SHALL have port g_resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port sleep_req, input, 1: core requests sleep (WFI); held high until woken.
REQ-006 SHALL have port core_idle, input, 1: pipeline empty, no outstanding memory transactions.
REQ-007 SHALL have port int_pending, input, 1: any enabled interrupt pending (wake event).
REQ-008 SHALL have port dbg_req, input, 1: debug halt request (wake event).
REQ-009 SHALL have port clk_req, output, 1: registered clock request, fed directly to the core clock gate's clk_req.
REQ-010 SHALL have port sleep_ack, output, 1: registered, high while the clock is gated or settling.
REQ-011 SHALL have port wake_pulse, output, 1: registered one-cycle pulse on return to RUN from WAKE.

Function
REQ-012 SHALL define wake_evt = int_pending | dbg_req.
REQ-013 SHALL implement FSM states RUN, DRAIN, HOLD, SLEEP, WAKE, plus an 8-bit down-counter cnt.
REQ-014 RUN: sleep_req && !wake_evt -> DRAIN; otherwise stay in RUN.
REQ-015 DRAIN: wake_evt || !sleep_req -> RUN (wake_evt takes priority over core_idle); else core_idle -> HOLD and load cnt=HOLD_CYCLES-1; else stay.
REQ-016 HOLD: wake_evt || !sleep_req || !core_idle -> RUN; else cnt==0 -> SLEEP; else decrement cnt.
REQ-017 SLEEP: wake_evt -> WAKE and load cnt=WAKE_CYCLES-1; otherwise stay, regardless of sleep_req or core_idle.
REQ-018 WAKE: cnt==0 -> RUN; else decrement cnt; wake_evt deasserting during WAKE does not abort the wake.
REQ-019 clk_req SHALL be registered as (next_state != SLEEP), so it is low in exactly the cycles where state==SLEEP.
REQ-020 sleep_ack SHALL be registered as (next_state == SLEEP || next_state == WAKE).
REQ-021 wake_pulse SHALL be high for exactly the one cycle after the WAKE->RUN transition, coinciding with sleep_ack falling.
REQ-022 Latency: minimum gating latency from sleep_req rising with core_idle already high is 1 (DRAIN) + 1 (HOLD entry) + HOLD_CYCLES cycles; clk_req rises 1 cycle after wake_evt is sampled in SLEEP.
REQ-023 A wake_evt asserted in the same cycle as HOLD with cnt==0 SHALL win: the FSM goes to RUN and clk_req never drops.
REQ-024 Counter SHALL never underflow; cnt is don't-care in RUN, DRAIN and SLEEP but is held, not free-running.

Reset
REQ-025 While g_resetn is low at a g_clk edge: state=RUN, cnt=0, clk_req=1, sleep_ack=0, wake_pulse=0.
REQ-026 Reset asserted mid-SLEEP or mid-WAKE SHALL restore clk_req=1 on the next g_clk edge, with no wake_pulse.

Configuration
REQ-027 Macro CORE_CLK_REQ_HYSTERESIS_EN defined: HOLD state and HOLD_CYCLES are used as above.
REQ-028 Macro undefined: HOLD state absent; in DRAIN, core_idle && !wake_evt && sleep_req -> SLEEP directly; HOLD_CYCLES is ignored.

Structure
REQ-029 The state enum typedef (3-bit encoding) and the reset-state constant SHALL live in the shared core package.
REQ-030 SHALL have no sub-modules; the counter is inline.
REQ-031 All logic SHALL be single-clock on g_clk with no latches; the gating latch stays in the clock gate cell.

Verification
REQ-032 Defaults, macro on: sleep_req=1 and core_idle=1 from cycle 0 -> DRAIN@1, HOLD@2, SLEEP@6, clk_req=0 from cycle 6.
REQ-033 In SLEEP, int_pending pulses for 1 cycle at cycle T -> clk_req=1 at T+1, WAKE for 2 cycles, wake_pulse=1 and sleep_ack=0 at T+3.
REQ-034 In HOLD with cnt==0, dbg_req=1 -> next state RUN, clk_req stays 1 throughout, no wake_pulse.
REQ-035 In DRAIN, core_idle=0 for 10 cycles then sleep_req dropped -> returns to RUN, clk_req never low.
REQ-036 g_resetn=0 for 1 cycle while in SLEEP -> clk_req=1, sleep_ack=0 and state RUN next cycle, wake_pulse stays 0.
REQ-037 Macro off, sleep_req=core_idle=1 at cycle 0 -> DRAIN@1, SLEEP@2, clk_req=0 at 2.

Source files
------------

// File: rtl/core_clk_req_ctrl_pkg.sv
// Shared definitions for the core clock-request controller: the FSM state
// encoding, the reset state and the hysteresis/settle counter width.
package core_clk_req_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_HOLD  = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } clk_state_e;

  localparam clk_state_e RESET_STATE = ST_RUN;

endpackage

// File: rtl/core_clk_req_ctrl.sv
// Core clock-request controller. Gates the core clock after a sleep request
// once the pipeline is idle, and ungates it (with a settle window) on an
// interrupt or debug request. clk_req drives the clock gate cell directly.
// Build option: define CORE_CLK_REQ_HYSTERESIS_EN to insert the HOLD_CYCLES
// idle-hysteresis window between DRAIN and SLEEP.
module core_clk_req_ctrl
  import core_clk_req_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic sleep_req,
  input  logic core_idle,
  input  logic int_pending,
  input  logic dbg_req,
  output logic clk_req,
  output logic sleep_ack,
  output logic wake_pulse
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  clk_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_req_q, clk_req_d;
  logic             sleep_ack_q, sleep_ack_d;
  logic             wake_pulse_q, wake_pulse_d;
  logic             wake_evt;

  assign wake_evt = int_pending | dbg_req;

  // State, counter and registered outputs; reset leaves the clock requested.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= RESET_STATE;
      cnt_q        <= '0;
      clk_req_q    <= 1'b1;
      sleep_ack_q  <= 1'b0;
      wake_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_req_q    <= clk_req_d;
      sleep_ack_q  <= sleep_ack_d;
      wake_pulse_q <= wake_pulse_d;
    end
  end

  // Next-state and counter: wake events always beat entry into SLEEP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (sleep_req && !wake_evt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wake_evt || !sleep_req) begin
          state_d = ST_RUN;
        end else if (core_idle) begin
`ifdef CORE_CLK_REQ_HYSTERESIS_EN
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
`else
          // cnt is unused while asleep; loading the hold value keeps the
          // DRAIN exit load identical with and without hysteresis.
          state_d = ST_SLEEP;
          cnt_d   = HOLD_LOAD;
`endif
        end
      end
`ifdef CORE_CLK_REQ_HYSTERESIS_EN
      ST_HOLD: begin
        if (wake_evt || !sleep_req || !core_idle) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          state_d = ST_SLEEP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_SLEEP: begin
        if (wake_evt) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // The settle window runs to completion even if wake_evt drops.
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Outputs are looked ahead from the next state so they register cleanly.
  always_comb begin
    clk_req_d    = (state_d != ST_SLEEP);
    sleep_ack_d  = (state_d == ST_SLEEP) || (state_d == ST_WAKE);
    wake_pulse_d = (state_q == ST_WAKE) && (state_d == ST_RUN);
  end

  assign clk_req    = clk_req_q;
  assign sleep_ack  = sleep_ack_q;
  assign wake_pulse = wake_pulse_q;

endmodule

// File: tb/tb_core_clk_req_ctrl.sv
// Self-checking bench for core_clk_req_ctrl. A cycle-level behavioural model
// (counts of qualifying idle cycles and remaining settle cycles) predicts the
// three outputs every cycle; directed literal expectations pin key timings.
module tb_core_clk_req_ctrl;

  localparam int HOLD_CYCLES = 4;
  localparam int WAKE_CYCLES = 2;
`ifdef CORE_CLK_REQ_HYSTERESIS_EN
  localparam int SLEEP_AT = HOLD_CYCLES + 1;
  localparam int GATE     = HOLD_CYCLES + 2;
`else
  localparam int SLEEP_AT = 1;
  localparam int GATE     = 2;
`endif

  localparam int S_CLK = 0;
  localparam int S_ACK = 1;
  localparam int S_PUL = 2;

  typedef struct {
    int    cyc;
    int    sig;
    bit    val;
    string name;
  } lit_t;

  logic g_clk = 1'b0;
  logic g_resetn;
  logic sleep_req, core_idle, int_pending, dbg_req;
  logic clk_req, sleep_ack, wake_pulse;

  core_clk_req_ctrl #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .sleep_req  (sleep_req),
    .core_idle  (core_idle),
    .int_pending(int_pending),
    .dbg_req    (dbg_req),
    .clk_req    (clk_req),
    .sleep_ack  (sleep_ack),
    .wake_pulse (wake_pulse)
  );

  always #5 g_clk = ~g_clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  lit_t lits[$];

  // Model: asleep flag, settle cycles remaining, and a progress count toward
  // gating (0 = running, 1 = request accepted, each further idle cycle +1).
  int m_asleep = 0;
  int m_waking = 0;
  int m_prog   = 0;
  bit e_clk = 1'b1;
  bit e_ack = 1'b0;
  bit e_pul = 1'b0;

  always @(posedge g_clk) begin
    automatic int a = m_asleep;
    automatic int w = m_waking;
    automatic int s = m_prog;
    automatic bit p = 1'b0;
    automatic bit wake = int_pending | dbg_req;
    if (!g_resetn) begin
      a = 0; w = 0; s = 0;
    end else if (a != 0) begin
      if (wake) begin
        a = 0; w = WAKE_CYCLES;
      end
    end else if (w > 0) begin
      w = w - 1;
      if (w == 0) p = 1'b1;
    end else if (wake || !sleep_req) begin
      s = 0;
    end else if (s == 0) begin
      s = 1;
    end else if (!core_idle) begin
      if (s >= 2) s = 0;
    end else if (s == SLEEP_AT) begin
      a = 1; s = 0;
    end else begin
      s = s + 1;
    end
    m_asleep <= a;
    m_waking <= w;
    m_prog   <= s;
    e_clk    <= (a == 0);
    e_ack    <= (a != 0) || (w > 0);
    e_pul    <= p;
    cyc      <= cyc + 1;
  end

  function automatic bit dut_sig(int sig);
    case (sig)
      S_CLK:   return clk_req;
      S_ACK:   return sleep_ack;
      default: return wake_pulse;
    endcase
  endfunction

  // Single compare process: model check every cycle plus literal expectations.
  always @(negedge g_clk) begin
    if (cyc >= 1) begin
      total++;
      if (clk_req !== e_clk) begin
        bad++;
        $display("FAIL model_clk_req cyc=%0d got=%b want=%b", cyc, clk_req, e_clk);
      end
      total++;
      if (sleep_ack !== e_ack) begin
        bad++;
        $display("FAIL model_sleep_ack cyc=%0d got=%b want=%b", cyc, sleep_ack, e_ack);
      end
      total++;
      if (wake_pulse !== e_pul) begin
        bad++;
        $display("FAIL model_wake_pulse cyc=%0d got=%b want=%b", cyc, wake_pulse, e_pul);
      end
      foreach (lits[i]) begin
        if (lits[i].cyc == cyc) begin
          total++;
          if (dut_sig(lits[i].sig) !== lits[i].val) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", lits[i].name, cyc,
                     dut_sig(lits[i].sig), lits[i].val);
          end
        end else if (done && lits[i].cyc > cyc) begin
          total++;
          bad++;
          $display("FAIL %s never reached (cyc=%0d)", lits[i].name, lits[i].cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #2;
  endtask

  task automatic expect_at(input int c, input int sig, input bit val, input string name);
    lit_t l;
    l.cyc = c; l.sig = sig; l.val = val; l.name = name;
    lits.push_back(l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t, r;
    g_resetn = 1'b0; sleep_req = 1'b0; core_idle = 1'b0;
    int_pending = 1'b0; dbg_req = 1'b0;
    tick(); tick(); tick();
    expect_at(cyc, S_CLK, 1'b1, "rst_clk_req");
    expect_at(cyc, S_ACK, 1'b0, "rst_sleep_ack");
    expect_at(cyc, S_PUL, 1'b0, "rst_wake_pulse");
    g_resetn = 1'b1;
    tick();

    // Gate with idle already high, then a one-cycle interrupt wake.
    c0 = cyc; sleep_req = 1'b1; core_idle = 1'b1;
    expect_at(c0 + GATE - 1, S_CLK, 1'b1, "pre_gate_clk");
    expect_at(c0 + GATE,     S_CLK, 1'b0, "gated_clk");
    expect_at(c0 + GATE,     S_ACK, 1'b1, "gated_ack");
    repeat (GATE + 3) tick();
    t = cyc; int_pending = 1'b1;
    expect_at(t,     S_CLK, 1'b0, "still_gated");
    expect_at(t + 1, S_CLK, 1'b1, "wake_clk_req");
    expect_at(t + 2, S_ACK, 1'b1, "settle_ack");
    expect_at(t + 2, S_PUL, 1'b0, "settle_no_pulse");
    expect_at(t + 3, S_PUL, 1'b1, "wake_pulse");
    expect_at(t + 3, S_ACK, 1'b0, "ack_fall");
    expect_at(t + 4, S_PUL, 1'b0, "pulse_one_cycle");
    tick();
    int_pending = 1'b0; sleep_req = 1'b0; core_idle = 1'b0;
    repeat (5) tick();

    // Wake event on the last cycle before gating wins.
    c0 = cyc; sleep_req = 1'b1; core_idle = 1'b1;
    repeat (GATE - 1) tick();
    dbg_req = 1'b1;
    expect_at(cyc,     S_CLK, 1'b1, "late_wake_clk_now");
    expect_at(cyc + 1, S_CLK, 1'b1, "late_wake_clk_next");
    expect_at(cyc + 1, S_ACK, 1'b0, "late_wake_ack");
    expect_at(cyc + 2, S_PUL, 1'b0, "late_wake_no_pulse");
    tick();
    dbg_req = 1'b0; sleep_req = 1'b0; core_idle = 1'b0;
    repeat (4) tick();

    // Long drain with a busy core, then the request is withdrawn.
    sleep_req = 1'b1; core_idle = 1'b0;
    repeat (10) tick();
    expect_at(cyc, S_CLK, 1'b1, "drain_busy_clk");
    sleep_req = 1'b0;
    tick();
    core_idle = 1'b1;
    repeat (3) tick();
    expect_at(cyc, S_CLK, 1'b1, "drain_exit_clk");
    core_idle = 1'b0;

    // Request with a wake event already pending never leaves RUN.
    sleep_req = 1'b1; core_idle = 1'b1; int_pending = 1'b1;
    repeat (8) tick();
    expect_at(cyc, S_CLK, 1'b1, "pending_wake_blocks");
    sleep_req = 1'b0; core_idle = 1'b0; int_pending = 1'b0;
    tick();

    // SLEEP ignores sleep_req/core_idle; reset while asleep.
    sleep_req = 1'b1; core_idle = 1'b1;
    repeat (GATE + 1) tick();
    sleep_req = 1'b0; core_idle = 1'b0;
    repeat (3) tick();
    expect_at(cyc, S_CLK, 1'b0, "sleep_holds");
    r = cyc; g_resetn = 1'b0;
    expect_at(r + 1, S_CLK, 1'b1, "sleep_rst_clk");
    expect_at(r + 1, S_ACK, 1'b0, "sleep_rst_ack");
    expect_at(r + 1, S_PUL, 1'b0, "sleep_rst_pulse");
    tick();
    g_resetn = 1'b1;
    expect_at(r + 2, S_PUL, 1'b0, "sleep_rst_no_pulse");
    repeat (3) tick();

    // Held debug wake, reset during the settle window: no wake pulse.
    sleep_req = 1'b1; core_idle = 1'b1;
    repeat (GATE + 1) tick();
    t = cyc; dbg_req = 1'b1;
    tick();
    g_resetn = 1'b0; sleep_req = 1'b0; core_idle = 1'b0; dbg_req = 1'b0;
    expect_at(t + 1, S_ACK, 1'b1, "wake_settling");
    expect_at(t + 2, S_CLK, 1'b1, "wake_rst_clk");
    expect_at(t + 2, S_ACK, 1'b0, "wake_rst_ack");
    expect_at(t + 3, S_PUL, 1'b0, "wake_rst_no_pulse");
    tick();
    g_resetn = 1'b1;
    repeat (4) tick();

    done = 1'b1;
    @(negedge g_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
